// File: rtl/multi_stage_alu_seq.sv
// multi_stage_alu_seq: self-sequenced bus ALU, latches A, samples B, registers G + flags, drives G back onto the bus
module multi_stage_alu_seq #(
  parameter int N          = 10,
  parameter int OUT_CYCLES = 1
) (
  input  logic         CLK,
  input  logic         RESETn,
  input  logic [N-1:0] BUS_IN,
  input  logic [3:0]   FN,
  input  logic         START,
  input  logic         ACC,
  output logic         BUSY,
  output logic         DONE,
  output logic         OUT_EN,
  output logic [N-1:0] BUS_OUT,
  output logic         Z_F,
  output logic         C_F,
  output logic         V_F
);
  localparam int CW = OUT_CYCLES > 1 ? $clog2(OUT_CYCLES) : 1;
  typedef enum logic [1:0] {IDLE, EXEC, DRIVE} state_t;
  state_t        state_q, state_d;
  logic [N-1:0]  a_q, a_d, g_q, g_d, res;
  logic [3:0]    fn_q, fn_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          z_q, z_d, c_q, c_d, v_q, v_d, c_r, v_r, last;
  logic [N:0]    add_s, sub_s, inc_s, dec_s;
  assign add_s = {1'b0, a_q} + {1'b0, BUS_IN};
  assign sub_s = {1'b0, a_q} - {1'b0, BUS_IN};
  assign inc_s = {1'b0, a_q} + (N+1)'(1);
  assign dec_s = {1'b0, a_q} - (N+1)'(1);
  // B is taken live from the bus; this result is only committed in EXEC
  always_comb begin
    res = a_q;
    c_r = 1'b0;
    v_r = 1'b0;
    case (fn_q)
      4'd0: begin
        res = add_s[N-1:0];
        c_r = add_s[N];
        v_r = (a_q[N-1] == BUS_IN[N-1]) && (add_s[N-1] != a_q[N-1]);
      end
      4'd1: begin
        res = sub_s[N-1:0];
        c_r = ~sub_s[N];
        v_r = (a_q[N-1] != BUS_IN[N-1]) && (sub_s[N-1] != a_q[N-1]);
      end
      4'd2: res = a_q & BUS_IN;
      4'd3: res = a_q | BUS_IN;
      4'd4: res = a_q ^ BUS_IN;
      4'd5: res = ~a_q;
      4'd6: begin
        res = {a_q[N-2:0], 1'b0};
        c_r = a_q[N-1];
      end
      4'd7: begin
        res = {1'b0, a_q[N-1:1]};
        c_r = a_q[0];
      end
      4'd8: res = BUS_IN;
      4'd9: begin
        res = inc_s[N-1:0];
        c_r = inc_s[N];
        v_r = ~a_q[N-1] & inc_s[N-1];
      end
      4'd10: begin
        res = dec_s[N-1:0];
        c_r = ~dec_s[N];
        v_r = a_q[N-1] & ~dec_s[N-1];
      end
      default: ;
    endcase
  end
  assign last = cnt_q == CW'(OUT_CYCLES - 1);
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    g_d     = g_q;
    fn_d    = fn_q;
    cnt_d   = cnt_q;
    z_d     = z_q;
    c_d     = c_q;
    v_d     = v_q;
    case (state_q)
      IDLE: if (START) begin
        fn_d    = FN;
        a_d     = ACC ? g_q : BUS_IN;
        state_d = EXEC;
      end
      EXEC: begin
        g_d     = res;
        z_d     = res == '0;
        c_d     = c_r;
        v_d     = v_r;
        cnt_d   = '0;
        state_d = DRIVE;
      end
      DRIVE: begin
        cnt_d   = cnt_q + CW'(1);
        state_d = last ? IDLE : DRIVE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge CLK) begin
    if (!RESETn) begin
      state_q <= IDLE;
      a_q     <= '0;
      g_q     <= '0;
      fn_q    <= '0;
      cnt_q   <= '0;
      z_q     <= 1'b1;
      c_q     <= 1'b0;
      v_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      g_q     <= g_d;
      fn_q    <= fn_d;
      cnt_q   <= cnt_d;
      z_q     <= z_d;
      c_q     <= c_d;
      v_q     <= v_d;
    end
  end
  assign BUSY    = state_q != IDLE;
  assign OUT_EN  = state_q == DRIVE;
  assign DONE    = OUT_EN && last;
  assign BUS_OUT = OUT_EN ? g_q : {N{1'bz}};
  assign Z_F     = z_q;
  assign C_F     = c_q;
  assign V_F     = v_q;
endmodule
